// File: rtl/etapa_fetch_if.sv
// Bundle between the IF stage and its surroundings:
// the instruction-memory read port, hazard/redirect controls and the IF/ID outputs.
interface etapa_fetch_if #(
  parameter int NBITS = 32
);
  // Instruction memory: address out, read data back one cycle later
  logic [NBITS-1:0] pc;
  logic [NBITS-1:0] instruction;
  // Hazard unit and branch/jump resolution in ID
  logic             stall;
  logic             redirect;
  logic [NBITS-1:0] redirect_target;
  // IF/ID pipeline register contents
  logic [NBITS-1:0] ifid_instruction;
  logic [NBITS-1:0] ifid_pc_plus4;
  logic             ifid_valid;
  logic             halt;

  // Fetch-stage view
  modport master (
    output pc,
    input  instruction,
    input  stall,
    input  redirect,
    input  redirect_target,
    output ifid_instruction,
    output ifid_pc_plus4,
    output ifid_valid,
    output halt
  );

  // Memory / control / decode view
  modport slave (
    input  pc,
    output instruction,
    output stall,
    output redirect,
    output redirect_target,
    input  ifid_instruction,
    input  ifid_pc_plus4,
    input  ifid_valid,
    input  halt
  );
endinterface

// File: rtl/etapa_fetch.sv
// MIPS IF stage: owns the PC, addresses a 1-cycle synchronous instruction
// memory, pairs each returned word with its PC+4 in the IF/ID register, and
// handles stall replay, redirect flush and a sticky HALT.
module etapa_fetch #(
  parameter int               NBITS     = 32,
  parameter logic [NBITS-1:0] RESET_PC  = '0,
  parameter logic [NBITS-1:0] HALT_CODE = '1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  etapa_fetch_if.master         io_fetch
);

  localparam logic [NBITS-1:0] PC_STEP = NBITS'(4);

  // Next address to request, and the address/validity of the word currently
  // arriving on the memory read-data bus.
  logic [NBITS-1:0] r_pc;
  logic [NBITS-1:0] r_req_pc;
  logic             r_req_valid;
  // IF/ID register and sticky halt
  logic [NBITS-1:0] r_ifid_instr;
  logic [NBITS-1:0] r_ifid_pc4;
  logic             r_ifid_valid;
  logic             r_halt;

  logic [NBITS-1:0] w_fetch_pc;
  logic             w_halt_hit;

  // A real word equal to HALT_CODE is about to enter IF/ID
  assign w_halt_hit = r_req_valid && (io_fetch.instruction == HALT_CODE);

  // Memory address: a plain stall re-reads the pending word so it is not lost;
  // a redirect wins over a stall; once halted the address stays put.
  always_comb begin
    w_fetch_pc = r_pc;
    if (!i_rst_n) begin
      w_fetch_pc = RESET_PC;
    end else if (r_halt) begin
      w_fetch_pc = r_pc;
    end else if (io_fetch.stall && !io_fetch.redirect) begin
      w_fetch_pc = r_req_pc;
    end
  end

  // PC, pending request and IF/ID update: reset > halt > redirect > stall > advance
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc         <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_req_valid  <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
      r_halt       <= 1'b0;
    end else if (r_halt) begin
      r_ifid_instr <= '0;
      r_ifid_valid <= 1'b0;
    end else if (io_fetch.redirect) begin
      r_pc         <= io_fetch.redirect_target;
      r_req_valid  <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_valid <= 1'b0;
    end else if (!io_fetch.stall) begin
      r_ifid_instr <= r_req_valid ? io_fetch.instruction : '0;
      r_ifid_pc4   <= r_req_pc + PC_STEP;
      r_ifid_valid <= r_req_valid;
      r_req_pc     <= r_pc;
      r_req_valid  <= 1'b1;
      r_pc         <= r_pc + PC_STEP;
      if (w_halt_hit) begin
        r_halt <= 1'b1;
      end
    end
  end

  assign io_fetch.pc               = w_fetch_pc;
  assign io_fetch.ifid_instruction = r_ifid_instr;
  assign io_fetch.ifid_pc_plus4    = r_ifid_pc4;
  assign io_fetch.ifid_valid       = r_ifid_valid;
  assign io_fetch.halt             = r_halt;

endmodule

// File: tb/tb_etapa_fetch.sv
// Bench for etapa_fetch: directed vector table, wrap-around sequence on a
// second instance, then random stall/redirect/reset traffic against a
// stream-level reference model.
module tb_etapa_fetch;

  localparam logic [31:0] HALT_W = 32'hFFFFFFFF;
  localparam int          NVEC   = 24;
  localparam int          NRAND  = 1500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst2_n;
  logic [31:0] halt_addr;

  int total = 0;
  int bad   = 0;

  etapa_fetch_if #(.NBITS(32)) bus  ();
  etapa_fetch_if #(.NBITS(32)) bus2 ();

  etapa_fetch #(.NBITS(32), .RESET_PC(32'h0), .HALT_CODE(HALT_W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .io_fetch (bus)
  );

  etapa_fetch #(.NBITS(32), .RESET_PC(32'hFFFFFFF8), .HALT_CODE(HALT_W)) dut_wrap (
    .i_clk    (clk),
    .i_rst_n  (rst2_n),
    .io_fetch (bus2)
  );

  always #5 clk = ~clk;

  // Memory contents: a distinct non-HALT word per address, HALT at halt_addr
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] ha);
    return (a == ha) ? HALT_W : {~a[15:0], a[15:0]};
  endfunction

  // Synchronous-read instruction memories
  always @(posedge clk) begin
    bus.instruction  <= mem_word(bus.pc, halt_addr);
    bus2.instruction <= mem_word(bus2.pc, halt_addr);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] target;
    logic [31:0] exp_opc;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic        exp_halt;
  } vec_t;

  vec_t tbl [NVEC];

  task automatic setv(input int i, input logic r, input logic s, input logic d,
                      input logic [31:0] t, input logic [31:0] opc,
                      input logic v, input logic [31:0] a, input logic h);
    tbl[i] = '{r, s, d, t, opc, v, a, h};
  endtask

  // Stream-level reference model state
  logic [31:0] m_next;
  int          m_bub;
  logic        m_halted;
  logic [31:0] m_hpc;
  logic        m_iv;
  logic [31:0] m_ii;
  logic [31:0] m_ip4;

  initial begin
    logic r, s, d;
    logic [31:0] t, w, exp_opc;
    bit skip;

    rst_n  = 1'b0;
    rst2_n = 1'b0;
    halt_addr = 32'd20;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = '0;
    bus2.stall = 1'b0; bus2.redirect = 1'b0; bus2.redirect_target = '0;

    // ---------------- directed vectors ----------------
    //       rst st rd tgt  opc  v  addr h
    setv( 0, 0, 0, 0,   0,   0, 0,   0, 0);
    setv( 1, 0, 0, 0,   0,   0, 0,   0, 0);
    setv( 2, 1, 0, 0,   0,   0, 0,   0, 0);
    setv( 3, 1, 0, 0,   0,   4, 1,   0, 0);
    setv( 4, 1, 0, 0,   0,   8, 1,   4, 0);
    setv( 5, 1, 1, 0,   0,   8, 1,   4, 0);
    setv( 6, 1, 1, 0,   0,   8, 1,   4, 0);
    setv( 7, 1, 0, 0,   0,  12, 1,   8, 0);
    setv( 8, 1, 0, 1,  52,  16, 0,   0, 0);
    setv( 9, 1, 0, 0,   0,  52, 0,   0, 0);
    setv(10, 1, 0, 0,   0,  56, 1,  52, 0);
    setv(11, 1, 1, 1, 100,  60, 0,   0, 0);
    setv(12, 1, 0, 0,   0, 100, 0,   0, 0);
    setv(13, 1, 0, 0,   0, 104, 1, 100, 0);
    setv(14, 1, 0, 1,  12, 108, 0,   0, 0);
    setv(15, 1, 0, 0,   0,  12, 0,   0, 0);
    setv(16, 1, 0, 0,   0,  16, 1,  12, 0);
    setv(17, 1, 0, 0,   0,  20, 1,  16, 0);
    setv(18, 1, 0, 0,   0,  24, 1,  20, 1);
    setv(19, 1, 0, 1,   0,  28, 0,   0, 1);
    setv(20, 1, 1, 0,   0,  28, 0,   0, 1);
    setv(21, 0, 0, 0,   0,   0, 0,   0, 0);
    setv(22, 1, 0, 0,   0,   0, 0,   0, 0);
    setv(23, 1, 0, 0,   0,   4, 1,   0, 0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n;
      bus.stall = tbl[i].stall;
      bus.redirect = tbl[i].redir;
      bus.redirect_target = tbl[i].target;
      #1;
      check("vec_o_pc", bus.pc, tbl[i].exp_opc);
      @(posedge clk);
      #1;
      $display("vec %0d: pc=%h ifid=%h pc4=%h v=%b halt=%b", i, bus.pc,
               bus.ifid_instruction, bus.ifid_pc_plus4, bus.ifid_valid, bus.halt);
      check("vec_valid", 32'(bus.ifid_valid), 32'(tbl[i].exp_valid));
      check("vec_instr", bus.ifid_instruction,
            tbl[i].exp_valid ? mem_word(tbl[i].exp_addr, halt_addr) : 32'h0);
      if (tbl[i].exp_valid)
        check("vec_pc4", bus.ifid_pc_plus4, tbl[i].exp_addr + 32'd4);
      check("vec_halt", 32'(bus.halt), 32'(tbl[i].exp_halt));
    end

    // ---------------- wrap-around on RESET_PC = FFFFFFF8 ----------------
    @(negedge clk); rst2_n = 1'b0; #1;
    check("wrap_rst_pc", bus2.pc, 32'hFFFFFFF8);
    @(posedge clk); #1;
    check("wrap_rst_valid", 32'(bus2.ifid_valid), 32'd0);
    @(negedge clk); rst2_n = 1'b1; #1;
    check("wrap_pc0", bus2.pc, 32'hFFFFFFF8);
    @(posedge clk); #1;
    check("wrap_e1_valid", 32'(bus2.ifid_valid), 32'd0);
    @(negedge clk); #1;
    check("wrap_pc1", bus2.pc, 32'hFFFFFFFC);
    @(posedge clk); #1;
    check("wrap_e2_instr", bus2.ifid_instruction, mem_word(32'hFFFFFFF8, halt_addr));
    check("wrap_e2_pc4", bus2.ifid_pc_plus4, 32'hFFFFFFFC);
    @(negedge clk); #1;
    check("wrap_pc2", bus2.pc, 32'h0);
    @(posedge clk); #1;
    check("wrap_e3_instr", bus2.ifid_instruction, mem_word(32'hFFFFFFFC, halt_addr));
    check("wrap_e3_pc4", bus2.ifid_pc_plus4, 32'h0);
    check("wrap_e3_valid", 32'(bus2.ifid_valid), 32'd1);
    @(negedge clk); #1;
    check("wrap_pc3", bus2.pc, 32'h4);
    $display("wrap: sequence FFFFFFF8 FFFFFFFC 0 4 applied");

    // ---------------- random traffic vs reference model ----------------
    halt_addr = 32'h200;
    m_next = 32'h0; m_bub = 1; m_halted = 1'b0; m_hpc = 32'h0;
    m_iv = 1'b0; m_ii = 32'h0; m_ip4 = 32'h0;
    for (int n = 0; n < NRAND; n++) begin
      r = (n == 0) || ($urandom_range(0, 99) < (m_halted ? 8 : 1));
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 9) == 0);
      t = 32'($urandom_range(0, 160)) << 2;
      @(negedge clk);
      rst_n = !r;
      bus.stall = s;
      bus.redirect = d;
      bus.redirect_target = t;
      #1;
      skip = 1'b0;
      if (r)                  exp_opc = 32'h0;
      else if (m_halted)      exp_opc = m_hpc;
      else if (d || !s)       exp_opc = m_next + ((m_bub > 0) ? 32'd0 : 32'd4);
      else if (m_bub == 0)    exp_opc = m_next;
      else begin              exp_opc = 32'h0; skip = 1'b1; end
      if (!skip) check("rnd_o_pc", bus.pc, exp_opc);

      @(posedge clk);
      // model: the IF/ID stream presents words m_next, m_next+4, ... after m_bub bubbles
      if (r) begin
        m_next = 32'h0; m_bub = 1; m_halted = 1'b0;
        m_iv = 1'b0; m_ii = 32'h0; m_ip4 = 32'h0;
      end else if (m_halted) begin
        m_iv = 1'b0; m_ii = 32'h0;
      end else if (d) begin
        m_next = t; m_bub = 1; m_iv = 1'b0; m_ii = 32'h0;
      end else if (s) begin
        // hold
      end else if (m_bub > 0) begin
        m_bub = m_bub - 1; m_iv = 1'b0; m_ii = 32'h0;
      end else begin
        w = mem_word(m_next, halt_addr);
        m_iv = 1'b1; m_ii = w; m_ip4 = m_next + 32'd4;
        if (w == HALT_W) begin
          m_halted = 1'b1;
          m_hpc = m_next + 32'd8;
        end
        m_next = m_next + 32'd4;
      end
      #1;
      $display("rnd %0d: rst=%b st=%b rd=%b tgt=%h pc=%h ifid=%h pc4=%h v=%b halt=%b",
               n, r, s, d, t, bus.pc, bus.ifid_instruction, bus.ifid_pc_plus4,
               bus.ifid_valid, bus.halt);
      check("rnd_valid", 32'(bus.ifid_valid), 32'(m_iv));
      check("rnd_instr", bus.ifid_instruction, m_ii);
      if (m_iv) check("rnd_pc4", bus.ifid_pc_plus4, m_ip4);
      check("rnd_halt", 32'(bus.halt), 32'(m_halted));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
